// File: rtl/demapper_sync.sv
`default_nettype none
// ============================================================================
// Module : demapper_sync
// Brief  : Frame-aligning receive demapper with payload extraction, ARQ bit
//          decode and per-frame CRC-8 check; geometry set by parameters.
// Rev    : 1.0
// ============================================================================
module demapper_sync #(
  parameter int         ROWS        = 4,
  parameter int         COLS        = 1040,
  parameter int         OH_COLS     = 16,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter int         SYNC_FRAMES = 2,
  parameter int         LOSS_FRAMES = 3,
  parameter int         CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_frame_data,
  input  logic             i_frame_data_valid,
  input  logic             i_frame_data_fas,
  output logic [7:0]       o_pyld_data,
  output logic             o_pyld_data_valid,
  output logic             o_pyld_sof,
  output logic             o_pyld_eof,
  output logic             o_crc_err,
  output logic             o_crc_err_valid,
  output logic             o_arq_en,
  output logic             o_arq_en_valid,
  output logic [7:0]       o_crc_val,
  output logic             o_in_frame,
  output logic [CNT_W-1:0] o_crc_err_cnt
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int HIT_W  = $clog2(SYNC_FRAMES + 1);
  localparam int MISS_W = $clog2(LOSS_FRAMES + 1);

  localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]  COL_EOF       = COL_W'(COLS - 2);
  localparam logic [COL_W-1:0]  COL_OH        = COL_W'(OH_COLS);
  localparam logic [HIT_W-1:0]  HIT_TGT       = HIT_W'(SYNC_FRAMES);
  localparam logic [MISS_W-1:0] MISS_TGT      = MISS_W'(LOSS_FRAMES);
  localparam logic              SYNC_ON_FIRST = (SYNC_FRAMES == 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   row, row_nxt, eff_row;
  logic [COL_W-1:0]   col, col_nxt, eff_col;
  logic [HIT_W-1:0]   hit_cnt, hit_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic               deliver, deliver_nxt;
  logic               take, is_pos0, at_zero;
  logic               is_crc_byte, is_payload, frame_end, crc_bad;
  logic [7:0]         crc_acc, crc_next;
  logic               arq_bit;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] r;
    r = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  assign at_zero = (row == '0) && (col == '0);

  // take: byte belongs to an aligned frame; is_pos0: byte is (re)treated as frame byte 0
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    col_nxt     = col;
    hit_nxt     = hit_cnt;
    miss_nxt    = miss_cnt;
    deliver_nxt = deliver;
    take        = 1'b0;
    is_pos0     = 1'b0;
    eff_row     = row;
    eff_col     = col;
    if (i_frame_data_valid) begin
      case (state)
        HUNT: begin
          if (i_frame_data_fas) begin
            is_pos0     = 1'b1;
            take        = 1'b1;
            hit_nxt     = HIT_W'(1);
            miss_nxt    = '0;
            state_nxt   = SYNC_ON_FIRST ? SYNC : PRESYNC;
            deliver_nxt = SYNC_ON_FIRST;
          end
        end
        PRESYNC: begin
          if (at_zero) begin
            if (i_frame_data_fas) begin
              is_pos0 = 1'b1;
              take    = 1'b1;
              hit_nxt = hit_cnt + HIT_W'(1);
              if (hit_cnt + HIT_W'(1) == HIT_TGT) begin
                state_nxt   = SYNC;
                deliver_nxt = 1'b1;
                miss_nxt    = '0;
              end else begin
                deliver_nxt = 1'b0;
              end
            end else begin
              state_nxt   = HUNT;
              hit_nxt     = '0;
              deliver_nxt = 1'b0;
            end
          end else if (i_frame_data_fas) begin
            is_pos0     = 1'b1;
            take        = 1'b1;
            hit_nxt     = HIT_W'(1);
            deliver_nxt = 1'b0;
          end else begin
            take = 1'b1;
          end
        end
        SYNC: begin
          take = 1'b1;
          if (at_zero) begin
            is_pos0 = 1'b1;
            if (i_frame_data_fas) begin
              miss_nxt    = '0;
              deliver_nxt = 1'b1;
            end else if (miss_cnt + MISS_W'(1) == MISS_TGT) begin
              take        = 1'b0;
              is_pos0     = 1'b0;
              state_nxt   = HUNT;
              miss_nxt    = '0;
              hit_nxt     = '0;
              deliver_nxt = 1'b0;
            end else begin
              miss_nxt    = miss_cnt + MISS_W'(1);
              deliver_nxt = 1'b1;
            end
          end
        end
        default: begin
          state_nxt   = HUNT;
          deliver_nxt = 1'b0;
        end
      endcase
    end
    if (is_pos0) begin
      eff_row = '0;
      eff_col = '0;
    end
    if (take) begin
      if (eff_col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col_nxt = eff_col + COL_W'(1);
        row_nxt = eff_row;
      end
    end else if (state_nxt == HUNT) begin
      row_nxt = '0;
      col_nxt = '0;
    end
  end

  assign is_crc_byte = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
  assign is_payload  = take && deliver_nxt && (eff_col >= COL_OH) && !is_crc_byte;
  assign frame_end   = take && deliver_nxt && is_crc_byte;
  assign crc_next    = crc8_byte(is_pos0 ? 8'h00 : crc_acc, i_frame_data);
  assign crc_bad     = (crc_acc != i_frame_data);
  assign o_in_frame  = (state == SYNC);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= HUNT;
      row               <= '0;
      col               <= '0;
      hit_cnt           <= '0;
      miss_cnt          <= '0;
      deliver           <= 1'b0;
      crc_acc           <= 8'h00;
      arq_bit           <= 1'b0;
      o_pyld_data       <= 8'h00;
      o_pyld_data_valid <= 1'b0;
      o_pyld_sof        <= 1'b0;
      o_pyld_eof        <= 1'b0;
      o_crc_err         <= 1'b0;
      o_crc_err_valid   <= 1'b0;
      o_arq_en          <= 1'b0;
      o_arq_en_valid    <= 1'b0;
      o_crc_val         <= 8'h00;
      o_crc_err_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
      deliver  <= deliver_nxt;
      if (take) begin
        if (!is_crc_byte) crc_acc <= crc_next;
        if (is_pos0)      arq_bit <= i_frame_data[0];
      end
      o_pyld_data_valid <= is_payload;
      if (is_payload) o_pyld_data <= i_frame_data;
      o_pyld_sof      <= is_payload && (eff_row == '0) && (eff_col == COL_OH);
      o_pyld_eof      <= is_payload && (eff_row == ROW_LAST) && (eff_col == COL_EOF);
      o_crc_err_valid <= frame_end;
      o_arq_en_valid  <= frame_end;
      if (frame_end) begin
        o_crc_err <= crc_bad;
        o_crc_val <= crc_acc;
        o_arq_en  <= arq_bit;
        if (crc_bad && (o_crc_err_cnt != '1)) o_crc_err_cnt <= o_crc_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demapper_sync.sv
`default_nettype none
// Directed bench for demapper_sync on a 2x8 frame with 2 overhead columns.
module tb_demapper_sync;

  localparam int ROWS = 2, COLS = 8, OH_COLS = 2, SYNC_FRAMES = 2, LOSS_FRAMES = 3, CNT_W = 16;
  localparam int FLEN = ROWS * COLS;

  logic clk = 1'b0;
  logic rst, valid, fas;
  logic [7:0] data;
  logic [7:0] pyld_data, crc_val;
  logic pyld_valid, sof, eof, crc_err, crc_err_valid, arq_en, arq_en_valid, in_frame;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  demapper_sync #(
    .ROWS(ROWS), .COLS(COLS), .OH_COLS(OH_COLS), .CRC_POLY(8'h07),
    .SYNC_FRAMES(SYNC_FRAMES), .LOSS_FRAMES(LOSS_FRAMES), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_frame_data(data), .i_frame_data_valid(valid), .i_frame_data_fas(fas),
    .o_pyld_data(pyld_data), .o_pyld_data_valid(pyld_valid),
    .o_pyld_sof(sof), .o_pyld_eof(eof),
    .o_crc_err(crc_err), .o_crc_err_valid(crc_err_valid),
    .o_arq_en(arq_en), .o_arq_en_valid(arq_en_valid),
    .o_crc_val(crc_val), .o_in_frame(in_frame), .o_crc_err_cnt(err_cnt)
  );

  int total = 0, bad = 0;
  logic [7:0] frm [FLEN];

  // output recorder
  logic [7:0] pay_q [$];
  bit sof_q [$];
  bit eof_q [$];
  int pulse_n = 0, arq_pulse_n = 0, gap_bad = 0;
  logic vin_q = 1'b0;
  int p0, pu0, ap0, g0;

  always @(posedge clk) vin_q <= valid;

  always @(negedge clk) begin
    if (pyld_valid) begin
      pay_q.push_back(pyld_data);
      sof_q.push_back(sof);
      eof_q.push_back(eof);
    end
    if (crc_err_valid) pulse_n++;
    if (arq_en_valid) arq_pulse_n++;
    if ((pyld_valid || crc_err_valid || arq_en_valid) && !vin_q) gap_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] crc_model();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < FLEN - 1; i++) c = crc_step(c, frm[i]);
    return c;
  endfunction

  task automatic byte_in(input logic [7:0] d, input logic v, input logic f);
    data = d; valid = v; fas = f;
    @(posedge clk); #1;
  endtask

  task automatic build_zero(input logic [7:0] ctrl, input logic [7:0] crcb);
    for (int i = 0; i < FLEN; i++) frm[i] = 8'h00;
    frm[0] = ctrl;
    frm[FLEN-1] = crcb;
  endtask

  // ctrl 8'h31 then "23456789"; CRC byte from the model
  task automatic build_d();
    string s;
    s = "123456789";
    for (int i = 0; i < FLEN; i++) frm[i] = 8'h00;
    for (int i = 0; i < 9; i++) frm[i] = s[i];
    frm[FLEN-1] = crc_model();
  endtask

  // leading zeros leave a zero-init CRC untouched, so this frame's CRC is the "123456789" check value
  task automatic build_f4();
    string s;
    s = "123456789";
    for (int i = 0; i < FLEN; i++) frm[i] = 8'h00;
    for (int i = 0; i < 9; i++) frm[6+i] = s[i];
    frm[FLEN-1] = 8'hF4;
  endtask

  task automatic snap();
    p0 = pay_q.size(); pu0 = pulse_n; ap0 = arq_pulse_n; g0 = gap_bad;
  endtask

  task automatic send_frame(input bit with_fas, input bit gap);
    for (int i = 0; i < FLEN; i++) begin
      byte_in(frm[i], 1'b1, with_fas && (i == 0));
      if (gap) byte_in(8'hAA, 1'b0, 1'b1);
    end
    byte_in(8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame_checks(input string tag, input bit delivered);
    logic [7:0] exp_q [$];
    int mism;
    if (delivered)
      for (int i = 0; i < FLEN - 1; i++)
        if ((i % COLS) >= OH_COLS) exp_q.push_back(frm[i]);
    check({tag, "_pay_cnt"}, 32'(pay_q.size() - p0), 32'(exp_q.size()));
    mism = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (p0 + k >= pay_q.size()) mism++;
      else begin
        if (pay_q[p0+k] !== exp_q[k]) mism++;
        if (sof_q[p0+k] !== (k == 0)) mism++;
        if (eof_q[p0+k] !== (k == exp_q.size() - 1)) mism++;
      end
    end
    check({tag, "_pay_mism"}, 32'(mism), 32'd0);
    check({tag, "_crc_pulse"}, 32'(pulse_n - pu0), 32'(delivered));
    check({tag, "_arq_pulse"}, 32'(arq_pulse_n - ap0), 32'(delivered));
  endtask

  logic [7:0] exp_c, exp_d;

  initial begin
    rst = 1'b1; valid = 1'b0; fas = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_frame", 32'(in_frame), 32'd0);
    check("rst_pvalid", 32'(pyld_valid), 32'd0);
    check("rst_crc_val", 32'(crc_val), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);

    build_zero(8'h00, 8'h00);
    snap(); send_frame(1'b1, 1'b0); frame_checks("fa", 1'b0);
    check("fa_in_frame", 32'(in_frame), 32'd0);
    snap(); send_frame(1'b1, 1'b0); frame_checks("fb", 1'b1);
    check("fb_in_frame", 32'(in_frame), 32'd1);
    check("fb_crc_err", 32'(crc_err), 32'd0);
    check("fb_crc_val", 32'(crc_val), 32'h00);
    check("fb_arq", 32'(arq_en), 32'd0);

    build_zero(8'h01, 8'h01);
    exp_c = crc_model();
    snap(); send_frame(1'b1, 1'b0); frame_checks("fc", 1'b1);
    check("fc_crc_err", 32'(crc_err), 32'(exp_c != 8'h01));
    check("fc_crc_val", 32'(crc_val), 32'(exp_c));
    check("fc_arq", 32'(arq_en), 32'd1);
    check("fc_cnt", 32'(err_cnt), 32'd1);

    build_d();
    exp_d = frm[FLEN-1];
    snap(); send_frame(1'b1, 1'b0); frame_checks("fd", 1'b1);
    check("fd_crc_err", 32'(crc_err), 32'd0);
    check("fd_crc_val", 32'(crc_val), 32'(exp_d));
    check("fd_arq", 32'(arq_en), 32'd1);
    check("fd_cnt", 32'(err_cnt), 32'd1);

    build_f4();
    snap(); send_frame(1'b1, 1'b0); frame_checks("ff4", 1'b1);
    check("ff4_crc_val", 32'(crc_val), 32'hF4);
    check("ff4_crc_err", 32'(crc_err), 32'd0);
    check("ff4_arq", 32'(arq_en), 32'd0);

    build_d();
    snap(); send_frame(1'b1, 1'b1); frame_checks("fgap", 1'b1);
    check("fgap_idle_out", 32'(gap_bad - g0), 32'd0);
    check("fgap_crc_val", 32'(crc_val), 32'(exp_d));
    check("fgap_crc_err", 32'(crc_err), 32'd0);

    build_zero(8'h00, 8'h00);
    for (int n = 0; n < LOSS_FRAMES - 1; n++) begin
      snap(); send_frame(1'b0, 1'b0); frame_checks("fly", 1'b1);
      check("fly_in_frame", 32'(in_frame), 32'd1);
    end
    snap(); send_frame(1'b0, 1'b0); frame_checks("loss", 1'b0);
    check("loss_in_frame", 32'(in_frame), 32'd0);
    snap(); send_frame(1'b1, 1'b0); frame_checks("presync", 1'b0);
    check("presync_in_frame", 32'(in_frame), 32'd0);
    build_d();
    snap(); send_frame(1'b1, 1'b0); frame_checks("resync", 1'b1);
    check("resync_in_frame", 32'(in_frame), 32'd1);
    check("resync_cnt", 32'(err_cnt), 32'd1);

    for (int i = 0; i < 8; i++) byte_in(frm[i], 1'b1, i == 0);
    rst = 1'b1; valid = 1'b0; fas = 1'b0;
    @(posedge clk); #1;
    check("mrst_outs", 32'({pyld_data, pyld_valid, sof, eof, crc_err, crc_err_valid,
                            arq_en, arq_en_valid, in_frame}), 32'd0);
    check("mrst_crc_val", 32'(crc_val), 32'd0);
    check("mrst_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    snap();
    for (int i = 8; i < FLEN; i++) byte_in(frm[i], 1'b1, 1'b0);
    byte_in(8'h00, 1'b0, 1'b0);
    frame_checks("mrst_tail", 1'b0);
    check("mrst_in_frame", 32'(in_frame), 32'd0);
    snap(); send_frame(1'b1, 1'b0); frame_checks("rh1", 1'b0);
    snap(); send_frame(1'b1, 1'b0); frame_checks("rh2", 1'b1);
    check("rh2_in_frame", 32'(in_frame), 32'd1);
    check("rh2_crc_err", 32'(crc_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
